// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetches over an imem req/ack handshake, decodes IR and
// sequences regfile/ALU/dmem/PC controls. R-type, I-ALU, LW and SW; anything else parks in TRAP.
module multicycle_ctrl #(
   parameter int          ALU_CTRL_W = 4,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req,
   input  logic                  imem_ack,
   input  logic [31:0]           imem_rdata,
   output logic                  dmem_req,
   input  logic                  dmem_ack,
   output logic                  memWrite,
   output logic                  memToReg,
   output logic                  regWrite,
   output logic                  ALUSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic [4:0]            rs1,
   output logic [4:0]            rs2,
   output logic [4:0]            rd,
   output logic [31:0]           imm32,
   output logic                  pcEn,
   output logic                  illegal
);

   localparam logic [ALU_CTRL_W-1:0] OP_ADD  = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] OP_SUB  = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] OP_AND  = ALU_CTRL_W'(2);
   localparam logic [ALU_CTRL_W-1:0] OP_OR   = ALU_CTRL_W'(3);
   localparam logic [ALU_CTRL_W-1:0] OP_XOR  = ALU_CTRL_W'(4);
   localparam logic [ALU_CTRL_W-1:0] OP_SLL  = ALU_CTRL_W'(5);
   localparam logic [ALU_CTRL_W-1:0] OP_SRL  = ALU_CTRL_W'(6);
   localparam logic [ALU_CTRL_W-1:0] OP_SRA  = ALU_CTRL_W'(7);
   localparam logic [ALU_CTRL_W-1:0] OP_SLT  = ALU_CTRL_W'(8);
   localparam logic [ALU_CTRL_W-1:0] OP_SLTU = ALU_CTRL_W'(9);

   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_I  = 7'b0010011;
   localparam logic [6:0] OPC_LD = 7'b0000011;
   localparam logic [6:0] OPC_ST = 7'b0100011;
   localparam logic [6:0] F7_ALT = 7'b0100000;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

   state_t                  state, nxt;
   logic [31:0]             ir;
   logic [6:0]              opc, f7;
   logic [2:0]              f3;
   logic                    legal, is_imm, is_ld, is_st;
   logic [ALU_CTRL_W-1:0]   op;
   logic [31:0]             imm_i, imm_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
         ir    <= NOP_INSTR;
      end else begin
         state <= nxt;
         if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      end
   end

   assign rs1   = ir[19:15];
   assign rs2   = ir[24:20];
   assign rd    = ir[11:7];
   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};

   always_comb begin
      opc    = ir[6:0];
      f3     = ir[14:12];
      f7     = ir[31:25];
      legal  = 1'b0;
      is_imm = 1'b0;
      is_ld  = 1'b0;
      is_st  = 1'b0;
      case (f3)
         3'b000:  op = OP_ADD;
         3'b001:  op = OP_SLL;
         3'b010:  op = OP_SLT;
         3'b011:  op = OP_SLTU;
         3'b100:  op = OP_XOR;
         3'b101:  op = OP_SRL;
         3'b110:  op = OP_OR;
         default: op = OP_AND;
      endcase
      case (opc)
         OPC_R: begin
            if (f7 == 7'b0000000) legal = 1'b1;
            else if (f7 == F7_ALT && f3 == 3'b000) begin
               legal = 1'b1;
               op    = OP_SUB;
            end else if (f7 == F7_ALT && f3 == 3'b101) begin
               legal = 1'b1;
               op    = OP_SRA;
            end
         end
         OPC_I: begin
            // ADDI keeps OP_ADD: IR[30] is immediate data here, not an opcode modifier
            is_imm = 1'b1;
            if (f3 == 3'b001) legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101) begin
               legal = (f7 == 7'b0000000) || (f7 == F7_ALT);
               if (f7 == F7_ALT) op = OP_SRA;
            end else legal = 1'b1;
         end
         OPC_LD: begin
            is_ld = 1'b1;
            legal = (f3 == 3'b010);
            op    = OP_ADD;
         end
         OPC_ST: begin
            is_st = 1'b1;
            legal = (f3 == 3'b010);
            op    = OP_ADD;
         end
         default: ;
      endcase
   end

   always_comb begin
      nxt        = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      memWrite   = 1'b0;
      memToReg   = 1'b0;
      regWrite   = 1'b0;
      pcEn       = 1'b0;
      illegal    = 1'b0;
      ALUSrc     = legal && (is_imm || is_ld || is_st);
      ALUControl = legal ? op : OP_ADD;
      imm32      = !legal ? 32'h0 : (is_st ? imm_s : ((is_imm || is_ld) ? imm_i : 32'h0));
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) nxt = S_DECODE;
         end
         S_DECODE: nxt = legal ? S_EXEC : S_TRAP;
         S_EXEC:   nxt = (is_ld || is_st) ? S_MEM : S_WB;
         S_MEM: begin
            dmem_req   = 1'b1;
            memWrite   = is_st;
            ALUControl = OP_ADD;
            if (dmem_ack) begin
               pcEn = is_st;
               nxt  = is_st ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            regWrite = 1'b1;
            pcEn     = 1'b1;
            memToReg = is_ld;
            nxt      = S_FETCH;
         end
         S_TRAP:  illegal = 1'b1;
         default: nxt = S_FETCH;
      endcase
      // Outputs are forced quiet while reset is held so a pending request drops at once
      if (!reset) begin
         imem_req   = 1'b0;
         dmem_req   = 1'b0;
         memWrite   = 1'b0;
         memToReg   = 1'b0;
         regWrite   = 1'b0;
         pcEn       = 1'b0;
         illegal    = 1'b0;
         ALUSrc     = 1'b0;
         ALUControl = OP_ADD;
         imm32      = 32'h0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction expected traces from an ISA-level model,
// checked every cycle, plus literal latency/field expectations for the key instructions.
module tb_multicycle_ctrl;

   localparam logic [2:0] PH_F = 3'd0, PH_D = 3'd1, PH_E = 3'd2, PH_M = 3'd3, PH_W = 3'd4, PH_T = 3'd5;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack, dmem_req, dmem_ack;
   logic [31:0] imem_rdata, imm32;
   logic        memWrite, memToReg, regWrite, ALUSrc, pcEn, illegal;
   logic [3:0]  ALUControl;
   logic [4:0]  rs1, rs2, rd;

   always #5 clk = ~clk;

   multicycle_ctrl #(.ALU_CTRL_W(4), .NOP_INSTR(32'h0000_0013)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite),
      .ALUSrc(ALUSrc), .ALUControl(ALUControl),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm32(imm32),
      .pcEn(pcEn), .illegal(illegal)
   );

   typedef struct packed {
      logic [2:0]  ph;
      logic        imem_req, dmem_req, mem_write, mem_to_reg, reg_write, pc_en, illegal;
      logic        fld, aluc_v, alu_src;
      logic [3:0]  aluc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
   } exp_t;

   exp_t        ex;
   bit          exp_valid;
   int          n_cmp, n_bad;
   int          ncyc, nrw, npc, nsw, nmtr, nill, pc_at;
   logic [4:0]  s_rs1, s_rs2, s_rd;
   logic        s_src;
   logic [3:0]  s_aluc;
   logic [31:0] s_imm;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   // ISA-level reference: legality, ALU function code and immediate straight from the encoding
   function automatic void mdl(input logic [31:0] ins, output bit ok, output int kind,
                               output logic [3:0] aluc, output logic [31:0] imm);
      int               f3op [8];
      int               f3;
      logic [6:0]       f7;
      bit               alt;
      logic signed [11:0] i12;
      f3op = '{0, 5, 8, 9, 4, 6, 3, 2};
      f3   = int'(ins[14:12]);
      f7   = ins[31:25];
      alt  = (f7 == 7'h20);
      ok = 0; kind = -1; aluc = 4'd0; imm = 32'd0;
      case (ins[6:0])
         7'h33: begin
            kind = 0;
            ok   = (f7 == 7'h00) || (alt && (f3 == 0 || f3 == 5));
            aluc = 4'(alt ? ((f3 == 0) ? 1 : 7) : f3op[f3]);
         end
         7'h13: begin
            kind = 1;
            ok   = !(f3 == 1 || f3 == 5) || (f7 == 7'h00) || (f3 == 5 && alt);
            aluc = 4'((f3 == 5 && alt) ? 7 : f3op[f3]);
            i12  = ins[31:20];
            imm  = 32'(i12);
         end
         7'h03: begin
            kind = 2; ok = (f3 == 2);
            i12  = ins[31:20];
            imm  = 32'(i12);
         end
         7'h23: begin
            kind = 3; ok = (f3 == 2);
            i12  = {ins[31:25], ins[11:7]};
            imm  = 32'(i12);
         end
         default: ;
      endcase
      if (!ok) begin aluc = 4'd0; imm = 32'd0; end
   endfunction

   function automatic logic [31:0] r_(input logic [6:0] f7, input logic [4:0] b, input logic [4:0] a,
                                      input logic [2:0] f3, input logic [4:0] d);
      return {f7, b, a, f3, d, 7'h33};
   endfunction
   function automatic logic [31:0] i_(input logic [11:0] im, input logic [4:0] a, input logic [2:0] f3,
                                      input logic [4:0] d, input logic [6:0] opc);
      return {im, a, f3, d, opc};
   endfunction
   function automatic logic [31:0] s_(input logic [11:0] im, input logic [4:0] b, input logic [4:0] a);
      return {im[11:5], b, a, 3'b010, im[4:0], 7'h23};
   endfunction

   always @(negedge clk) begin
      if (exp_valid) begin
         chk("imem_req", imem_req, ex.imem_req);
         chk("dmem_req", dmem_req, ex.dmem_req);
         chk("memWrite", memWrite, ex.mem_write);
         chk("regWrite", regWrite, ex.reg_write);
         chk("pcEn", pcEn, ex.pc_en);
         chk("illegal", illegal, ex.illegal);
         if (ex.reg_write) chk("memToReg", memToReg, ex.mem_to_reg);
         if (ex.fld) begin
            chk("rs1", rs1, ex.rs1);
            chk("rs2", rs2, ex.rs2);
            chk("rd", rd, ex.rd);
            chk("imm32", imm32, ex.imm);
            chk("ALUSrc", ALUSrc, ex.alu_src);
         end
         if (ex.aluc_v) chk("ALUControl", ALUControl, ex.aluc);
         ncyc++;
         if (regWrite) nrw++;
         if (pcEn) begin npc++; pc_at = ncyc; end
         if (dmem_req && memWrite) nsw++;
         if (regWrite && memToReg) nmtr++;
         if (illegal) nill++;
         if (ex.ph == PH_E) begin
            s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_src = ALUSrc; s_aluc = ALUControl; s_imm = imm32;
         end
      end
   end

   task automatic clr();
      ncyc = 0; nrw = 0; npc = 0; nsw = 0; nmtr = 0; nill = 0; pc_at = 0;
   endtask

   task automatic step(input exp_t e, input logic ia, input logic [31:0] rdat, input logic da);
      imem_ack = ia; imem_rdata = rdat; dmem_ack = da; ex = e; exp_valid = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic rst_checks();
      chk("rst_imem_req", imem_req, 0);  chk("rst_dmem_req", dmem_req, 0);
      chk("rst_memWrite", memWrite, 0);  chk("rst_memToReg", memToReg, 0);
      chk("rst_regWrite", regWrite, 0);  chk("rst_ALUSrc", ALUSrc, 0);
      chk("rst_pcEn", pcEn, 0);          chk("rst_illegal", illegal, 0);
      chk("rst_ALUControl", ALUControl, 0); chk("rst_imm32", imm32, 0);
      chk("rst_rd", rd, 0);              chk("rst_rs1", rs1, 0);
   endtask

   task automatic do_reset();
      exp_valid = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      reset = 1'b0;
      #2;
      rst_checks();
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // Runs one instruction with iw imem / dw dmem wait cycles (dw<0: never ack, stop in MEM);
   // nz drives acks in states that must ignore them.
   task automatic run(input logic [31:0] ins, input int iw, input int dw, input bit nz);
      exp_t e0, e;
      bit ok; int kind; logic [3:0] ac; logic [31:0] im; int nm;
      mdl(ins, ok, kind, ac, im);
      e0 = '0;
      e0.rs1 = ins[19:15]; e0.rs2 = ins[24:20]; e0.rd = ins[11:7];
      e0.imm = im; e0.aluc = ac; e0.alu_src = ok && (kind != 0);
      for (int i = 0; i <= iw; i++) begin
         e = e0; e.ph = PH_F; e.imem_req = 1'b1;
         step(e, (i == iw), (i == iw) ? ins : $urandom, nz);
      end
      e = e0; e.ph = PH_D; e.fld = ok;
      step(e, nz, $urandom, nz);
      if (!ok) begin
         for (int t = 0; t < 4; t++) begin
            e = e0; e.ph = PH_T; e.illegal = 1'b1;
            step(e, 1'b1, $urandom, 1'b1);
         end
         return;
      end
      e = e0; e.ph = PH_E; e.fld = 1'b1; e.aluc_v = 1'b1;
      step(e, nz, $urandom, nz);
      if (kind >= 2) begin
         nm = (dw < 0) ? 2 : dw + 1;
         for (int j = 0; j < nm; j++) begin
            e = e0; e.ph = PH_M; e.fld = 1'b1; e.dmem_req = 1'b1; e.mem_write = (kind == 3);
            e.aluc_v = 1'b1; e.aluc = 4'd0; e.pc_en = (kind == 3) && (j == dw);
            step(e, nz, $urandom, (j == dw));
         end
         if (dw < 0 || kind == 3) return;
      end
      e = e0; e.ph = PH_W; e.fld = 1'b1; e.reg_write = 1'b1; e.pc_en = 1'b1; e.mem_to_reg = (kind == 2);
      step(e, nz, $urandom, nz);
   endtask

   logic [31:0] good_v [13];
   logic [31:0] bad_v  [7];

   initial begin
      imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'h0; exp_valid = 1'b0;
      n_cmp = 0; n_bad = 0;
      clr();
      do_reset();

      // reset asserted while a load waits in MEM
      run(32'h0040A183, 0, -1, 0);
      exp_valid = 1'b0;
      #2;
      chk("t1_dmem_req_pre", dmem_req, 1);
      reset = 1'b0;
      #1;
      chk("t1_dmem_req_drop", dmem_req, 0);
      chk("t1_imem_req_rst", imem_req, 0);
      chk("t1_illegal_rst", illegal, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("t1_imem_req_first", imem_req, 1);
      chk("t1_illegal_after", illegal, 0);

      clr(); run(32'h002081B3, 0, 0, 0);
      chk("t2_cycles", ncyc, 4);  chk("t2_pc_at", pc_at, 4);
      chk("t2_npc", npc, 1);      chk("t2_nrw", nrw, 1);
      chk("t2_rs1", s_rs1, 1);    chk("t2_rs2", s_rs2, 2);   chk("t2_rd", s_rd, 3);
      chk("t2_src", s_src, 0);    chk("t2_aluc", s_aluc, 0);

      clr(); run(32'hFFF0A093, 2, 0, 1);
      chk("t3_imm", s_imm, 32'hFFFF_FFFF); chk("t3_src", s_src, 1);
      chk("t3_aluc", s_aluc, 8);          chk("t3_cycles", ncyc, 6);

      clr(); run(32'h0020A223, 0, 3, 0);
      chk("t4_store_cycles", nsw, 4); chk("t4_imm", s_imm, 4);
      chk("t4_npc", npc, 1);          chk("t4_nrw", nrw, 0);
      chk("t4_cycles", ncyc, 7);      chk("t4_pc_at", pc_at, 7);

      clr(); run(32'h0040A183, 0, 0, 0);
      chk("t5_cycles", ncyc, 5); chk("t5_nrw", nrw, 1);
      chk("t5_nmtr", nmtr, 1);   chk("t5_npc", npc, 1); chk("t5_pc_at", pc_at, 5);

      clr(); run(32'h4000F0B3, 0, 0, 1);
      chk("t6_nill", nill, 4); chk("t6_npc", npc, 0); chk("t6_nrw", nrw, 0);
      chk("t6_still_illegal", illegal, 1);
      do_reset();
      clr(); run(32'h0000006F, 0, 0, 0);
      chk("t6_jal_nill", nill, 4); chk("t6_jal_npc", npc, 0);
      do_reset();

      good_v = '{r_(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), r_(7'h20, 5'd3, 5'd2, 3'd5, 5'd5),
                 r_(7'h00, 5'd4, 5'd5, 3'd3, 5'd6), r_(7'h00, 5'd7, 5'd6, 3'd4, 5'd0),
                 r_(7'h00, 5'd1, 5'd2, 3'd6, 5'd7), r_(7'h00, 5'd1, 5'd2, 3'd1, 5'd8),
                 i_(12'h405, 5'd3, 3'd5, 5'd9, 7'h13), i_(12'h01F, 5'd3, 3'd5, 5'd10, 7'h13),
                 i_(12'h003, 5'd4, 3'd1, 5'd11, 7'h13), i_(12'h800, 5'd1, 3'd7, 5'd12, 7'h13),
                 i_(12'h7FF, 5'd2, 3'd4, 5'd13, 7'h13), i_(12'hFFC, 5'd5, 3'd2, 5'd14, 7'h03),
                 s_(12'h801, 5'd6, 5'd7)};
      for (int k = 0; k < 13; k++) begin
         clr(); run(good_v[k], k % 3, k % 2, k[0]);
         chk("legal_npc", npc, 1);
      end

      bad_v = '{i_(12'h401, 5'd1, 3'd1, 5'd1, 7'h13), i_(12'h004, 5'd1, 3'd0, 5'd3, 7'h03),
                {7'h00, 5'd2, 5'd1, 3'b001, 5'd4, 7'h23}, r_(7'h01, 5'd2, 5'd1, 3'd0, 5'd3),
                i_(12'h425, 5'd1, 3'd5, 5'd1, 7'h13), r_(7'h20, 5'd2, 5'd1, 3'd7, 5'd3),
                32'h0000_0037};
      for (int k = 0; k < 7; k++) begin
         clr(); run(bad_v[k], k % 2, 0, 1'b1);
         chk("bad_nill", nill, 4);
         do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
